// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared state and owner types for the data-memory arbiter
package arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_EXT_BURST} arb_state_t;
   typedef enum logic {OWN_CORE, OWN_EXT} arb_owner_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rtl/dmem_arbiter_rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // A lone requester always wins; on a tie the one that did not win last time goes.
   // 'last' is the index of the previous winner.
   always_comb begin
      gnt[0] = req[0] & (~req[1] | last);
      gnt[1] = req[1] & (~req[0] | ~last);
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data-memory port between the core and an external master
module dmem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic              ext_last,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_rvalid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int              CNT_W   = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

   arb_state_t       state, state_nxt;
   arb_owner_t       rr_last, rr_last_nxt;
   logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
   logic [1:0]       pick_gnt;
   logic             grant_core;
   logic             grant_ext;

   rr_pick2 u_pick (
      .req  ({ext_req, core_req}),
      .last (rr_last == OWN_EXT),
      .gnt  (pick_gnt)
   );

   // Grant decision and next-state; reset suppresses every grant so no write can slip through.
   always_comb begin
      grant_core   = 1'b0;
      grant_ext    = 1'b0;
      state_nxt    = state;
      rr_last_nxt  = rr_last;
      beat_cnt_nxt = beat_cnt;
      if (!reset) begin
         case (state)
            ARB_IDLE: begin
               grant_core = pick_gnt[0];
               grant_ext  = pick_gnt[1];
               if (grant_core) begin
                  rr_last_nxt = OWN_CORE;
               end
               if (grant_ext) begin
                  rr_last_nxt  = OWN_EXT;
                  beat_cnt_nxt = CNT_W'(1);
                  if (!ext_last && (MAX_BURST > 1)) begin
                     state_nxt = ARB_EXT_BURST;
                  end
               end
            end
            ARB_EXT_BURST: begin
               // Port locked to ext; rr_last stays EXT so a waiting core wins right after release.
               grant_ext = ext_req;
               if (!ext_req) begin
                  state_nxt = ARB_IDLE;
               end else begin
                  beat_cnt_nxt = beat_cnt + CNT_W'(1);
                  if (ext_last || (beat_cnt_nxt == MAX_CNT)) begin
                     state_nxt = ARB_IDLE;
                  end
               end
            end
            default: state_nxt = ARB_IDLE;
         endcase
      end
   end

   // State, round-robin history, beat counter and the registered ext read return.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ARB_IDLE;
         rr_last    <= OWN_EXT;
         beat_cnt   <= '0;
         ext_rvalid <= 1'b0;
         ext_rdata  <= '0;
      end else begin
         state      <= state_nxt;
         rr_last    <= rr_last_nxt;
         beat_cnt   <= beat_cnt_nxt;
         ext_rvalid <= grant_ext & ~ext_we;
         if (grant_ext && !ext_we) begin
            ext_rdata <= mem_rdata;
         end
      end
   end

   assign ext_gnt    = grant_ext;
   assign core_stall = core_req & ~grant_core & ~reset;
   assign core_rdata = mem_rdata;
   assign mem_addr   = grant_ext ? ext_addr  : core_addr;
   assign mem_wdata  = grant_ext ? ext_wdata : core_wdata;
   assign mem_we     = grant_ext ? ext_we    : (grant_core & core_we);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req, core_we;
   logic [31:0] core_addr, core_wdata, core_rdata;
   logic        core_stall;
   logic        ext_req, ext_we, ext_last;
   logic [31:0] ext_addr, ext_wdata, ext_rdata;
   logic        ext_gnt, ext_rvalid;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem     [0:63];
   logic [31:0] ref_mem [0:63];
   logic [31:0] sb[$];

   int   checks   = 0;
   int   failures = 0;
   logic mon_en   = 1'b0;
   logic exp_rv   = 1'b0;

   typedef struct packed {
      logic        rst;
      logic        cr;
      logic        cw;
      logic [31:0] ca;
      logic [31:0] cd;
      logic        er;
      logic        ew;
      logic        el;
      logic [31:0] ea;
      logic [31:0] ed;
      logic        xs;
      logic        xg;
      logic        xw;
   } vec_t;

   vec_t vecs[$];

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .core_stall (core_stall),
      .ext_req    (ext_req),
      .ext_we     (ext_we),
      .ext_last   (ext_last),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
      .ext_gnt    (ext_gnt),
      .ext_rdata  (ext_rdata),
      .ext_rvalid (ext_rvalid),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[7:2]];

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i]     = 32'hA000_0000 | i;
         ref_mem[i] = 32'hA000_0000 | i;
      end
      forever begin
         @(posedge clk);
         if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      end
   end

   function automatic vec_t mk(input logic rst, input logic cr, input logic cw,
                               input logic [31:0] ca, input logic [31:0] cd,
                               input logic er, input logic ew, input logic el,
                               input logic [31:0] ea, input logic [31:0] ed,
                               input logic xs, input logic xg, input logic xw);
      vec_t v;
      v.rst = rst; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
      v.er = er; v.ew = ew; v.el = el; v.ea = ea; v.ed = ed;
      v.xs = xs; v.xg = xg; v.xw = xw;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d got=%h exp=%h", nm, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      logic core_win;
      @(posedge clk);
      #1;
      reset = v.rst; core_req = v.cr; core_we = v.cw; core_addr = v.ca; core_wdata = v.cd;
      ext_req = v.er; ext_we = v.ew; ext_last = v.el; ext_addr = v.ea; ext_wdata = v.ed;
      #3;
      core_win = v.cr & ~v.xs & ~v.rst;
      chk("core_stall", idx, {31'd0, core_stall}, {31'd0, v.xs});
      chk("ext_gnt",    idx, {31'd0, ext_gnt},    {31'd0, v.xg});
      chk("mem_we",     idx, {31'd0, mem_we},     {31'd0, v.xw});
      chk("ext_rvalid", idx, {31'd0, ext_rvalid}, {31'd0, exp_rv});
      if (v.xg) begin
         chk("mem_addr_ext", idx, mem_addr, v.ea);
         if (v.ew) chk("mem_wdata_ext", idx, mem_wdata, v.ed);
      end else if (core_win) begin
         chk("mem_addr_core", idx, mem_addr, v.ca);
         if (v.cw) chk("mem_wdata_core", idx, mem_wdata, v.cd);
      end
      if (core_win && !v.cw) chk("core_rdata", idx, core_rdata, ref_mem[v.ca[7:2]]);
      if (v.xg && !v.ew) sb.push_back(ref_mem[v.ea[7:2]]);
      if (v.xg && v.ew) ref_mem[v.ea[7:2]] = v.ed;
      if (core_win && v.cw) ref_mem[v.ca[7:2]] = v.cd;
      exp_rv = ~v.rst & v.xg & ~v.ew;
   endtask

   // Scoreboard sink: every ext read return must match the oldest outstanding expectation.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (mon_en && ext_rvalid) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL rvalid_spurious got=%h exp=none", ext_rdata);
            end else begin
               e = sb.pop_front();
               if (ext_rdata !== e) begin
                  failures++;
                  $display("FAIL ext_rdata got=%h exp=%h", ext_rdata, e);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
      ext_req = 1'b0; ext_we = 1'b0; ext_last = 1'b0; ext_addr = '0; ext_wdata = '0;

      // reset held with both masters requesting: nothing granted, nothing written
      vecs.push_back(mk(1, 1,1,32'h10,32'h55,   1,1,0,32'h20,32'h66,  0,0,0));
      // core-only store then load
      vecs.push_back(mk(0, 1,1,32'h10,32'hDEAD, 0,0,0,32'h0,32'h0,    0,0,1));
      vecs.push_back(mk(0, 1,0,32'h10,32'h0,    0,0,0,32'h0,32'h0,    0,0,0));
      // tie after reset: core first, then ext
      vecs.push_back(mk(1, 0,0,32'h0,32'h0,     0,0,0,32'h0,32'h0,    0,0,0));
      vecs.push_back(mk(0, 1,0,32'h10,32'h0,    1,0,1,32'h20,32'h0,   0,0,0));
      vecs.push_back(mk(0, 1,0,32'h10,32'h0,    1,0,1,32'h20,32'h0,   1,1,0));
      vecs.push_back(mk(0, 0,0,32'h0,32'h0,     0,0,0,32'h0,32'h0,    0,0,0));
      // 3-beat read burst with core waiting throughout
      vecs.push_back(mk(0, 1,0,32'h14,32'h0,    0,0,0,32'h0,32'h0,    0,0,0));
      vecs.push_back(mk(0, 1,0,32'h14,32'h0,    1,0,0,32'h20,32'h0,   1,1,0));
      vecs.push_back(mk(0, 1,0,32'h14,32'h0,    1,0,0,32'h24,32'h0,   1,1,0));
      vecs.push_back(mk(0, 1,0,32'h14,32'h0,    1,0,1,32'h28,32'h0,   1,1,0));
      vecs.push_back(mk(0, 1,0,32'h14,32'h0,    0,0,0,32'h0,32'h0,    0,0,0));
      // unterminated write burst: forced release after 8 beats, core takes the 9th cycle
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(0, 1,0,32'h80,32'h0, 1,1,0,32'h80 + 4*i,32'h100 + i, 1,1,1));
      vecs.push_back(mk(0, 1,0,32'h80,32'h0,    1,0,0,32'h84,32'h0,   0,0,0));
      vecs.push_back(mk(0, 0,0,32'h0,32'h0,     1,0,1,32'h84,32'h0,   0,1,0));
      // reset on burst beat 2 aborts the burst and blocks the write
      vecs.push_back(mk(0, 0,0,32'h0,32'h0,     1,0,0,32'h20,32'h0,   0,1,0));
      vecs.push_back(mk(1, 1,0,32'h30,32'h0,    1,1,0,32'h30,32'hBAD, 0,0,0));
      vecs.push_back(mk(0, 1,0,32'h30,32'h0,    1,1,0,32'h30,32'hBAD, 0,0,0));
      // ext write then core load of the same word
      vecs.push_back(mk(0, 0,0,32'h0,32'h0,     1,1,1,32'h40,32'h1234,0,1,1));
      vecs.push_back(mk(0, 1,0,32'h40,32'h0,    0,0,0,32'h0,32'h0,    0,0,0));
      vecs.push_back(mk(0, 0,0,32'h0,32'h0,     0,0,0,32'h0,32'h0,    0,0,0));

      repeat (2) @(posedge clk);
      #4;
      chk("reset_rvalid", -1, {31'd0, ext_rvalid}, 32'd0);
      chk("reset_rdata",  -1, ext_rdata, 32'd0);
      mon_en = 1'b1;

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      @(posedge clk);
      #4;
      chk("sb_drained", -2, sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
